// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flags stage: condition codes,
// NZCV bit positions, flag-write masks and the partial flag-merge helper.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    localparam logic [1:0] FW_NZ = 2'b10;
    localparam logic [1:0] FW_CV = 2'b01;

    // N,Z and C,V are written as independent pairs so that logical ops
    // can leave the carry/overflow from an earlier arithmetic op intact.
    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] nxt,
                                               input logic [1:0] fw);
        logic [3:0] res;
        res = cur;
        if ((fw & FW_NZ) != 2'b00) begin
            res[N_IDX] = nxt[N_IDX];
            res[Z_IDX] = nxt[Z_IDX];
        end
        if ((fw & FW_CV) != 2'b00) begin
            res[C_IDX] = nxt[C_IDX];
            res[V_IDX] = nxt[V_IDX];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_unit_if.sv
// Bundle of the decoder/ALU inputs and the gated outputs of the
// condition stage. The pipeline side drives through master, the stage
// itself sits on slave.
interface cond_unit_if #(parameter int CNT_W = 32);

    logic             valid_in;
    logic             stall;
    logic             flush;
    logic [3:0]       cond;
    logic [1:0]       flag_write;
    logic [3:0]       alu_flags;
    logic             reg_write_in;
    logic             mem_write_in;
    logic             pc_src_in;
    logic             no_write_in;

    logic [3:0]       flags;
    logic             cond_ex;
    logic             valid_out;
    logic             reg_write;
    logic             mem_write;
    logic             pc_src;
    logic [CNT_W-1:0] cnt_exec;
    logic [CNT_W-1:0] cnt_skip;

    modport master (
        output valid_in, stall, flush, cond, flag_write, alu_flags,
               reg_write_in, mem_write_in, pc_src_in, no_write_in,
        input  flags, cond_ex, valid_out, reg_write, mem_write, pc_src,
               cnt_exec, cnt_skip
    );

    modport slave (
        input  valid_in, stall, flush, cond, flag_write, alu_flags,
               reg_write_in, mem_write_in, pc_src_in, no_write_in,
        output flags, cond_ex, valid_out, reg_write, mem_write, pc_src,
               cnt_exec, cnt_skip
    );

endinterface

// File: rtl/cond_check.sv
// Pure combinational ARM condition-field evaluator. Kept free of any
// state so the same block can be dropped into a branch-prediction check.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = flags[N_IDX];
    assign z_f = flags[Z_IDX];
    assign c_f = flags[C_IDX];
    assign v_f = flags[V_IDX];

    // Decode the condition code against the current NZCV bits.
    always_comb begin
        cond_ex = 1'b1;
        case (cond_e'(cond))
            EQ:      cond_ex = z_f;
            NE:      cond_ex = ~z_f;
            CS:      cond_ex = c_f;
            CC:      cond_ex = ~c_f;
            MI:      cond_ex = n_f;
            PL:      cond_ex = ~n_f;
            VS:      cond_ex = v_f;
            VC:      cond_ex = ~v_f;
            HI:      cond_ex = c_f & ~z_f;
            LS:      cond_ex = ~c_f | z_f;
            GE:      cond_ex = (n_f == v_f);
            LT:      cond_ex = (n_f != v_f);
            GT:      cond_ex = ~z_f & (n_f == v_f);
            LE:      cond_ex = z_f | (n_f != v_f);
            AL:      cond_ex = 1'b1;
            NV:      cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition/flags stage after the ALU: owns the NZCV register, gates the
// decoder write strobes with the instruction's condition, registers them
// for memory/writeback and counts executed versus squashed instructions.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    cond_unit_if.slave  bus
);

    logic [3:0]       flags_q;
    logic             valid_q;
    logic             reg_write_q;
    logic             mem_write_q;
    logic             pc_src_q;
    logic [CNT_W-1:0] cnt_exec_q;
    logic [CNT_W-1:0] cnt_skip_q;
    logic             cond_ex;
    logic             fire;

    // Condition is judged against the flags as they stand before this
    // edge, so a flag-setting instruction only affects its successor.
    cond_check u_check (
        .cond    (bus.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign fire = bus.valid_in & cond_ex & ~bus.flush & ~bus.stall;

    // Stage registers: reset beats flush beats stall beats normal update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q     <= 4'b0000;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            cnt_exec_q  <= '0;
            cnt_skip_q  <= '0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
        end else if (!bus.stall) begin
            if (fire) begin
                flags_q <= merge_flags(flags_q, bus.alu_flags, bus.flag_write);
            end
            valid_q     <= bus.valid_in;
            reg_write_q <= fire & bus.reg_write_in & ~bus.no_write_in;
            mem_write_q <= fire & bus.mem_write_in;
            pc_src_q    <= fire & bus.pc_src_in;
            if (bus.valid_in) begin
                if (cond_ex) begin
                    cnt_exec_q <= cnt_exec_q + CNT_W'(1);
                end else begin
                    cnt_skip_q <= cnt_skip_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.flags     = flags_q;
    assign bus.cond_ex   = cond_ex;
    assign bus.valid_out = valid_q;
    assign bus.reg_write = reg_write_q;
    assign bus.mem_write = mem_write_q;
    assign bus.pc_src    = pc_src_q;
    assign bus.cnt_exec  = cnt_exec_q;
    assign bus.cnt_skip  = cnt_skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: scoreboard model of the stage,
// condition truth-table sweep, directed vectors and a narrow-counter
// instance for wrap-around.
module tb_cond_unit;

    typedef struct {
        logic       valid;
        logic       stall;
        logic       flush;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       rw;
        logic       mw;
        logic       ps;
        logic       nw;
    } stim_t;

    typedef struct {
        logic [3:0]  flags;
        logic        valid_out;
        logic        rw;
        logic        mw;
        logic        ps;
        logic [31:0] cnt_exec;
        logic [31:0] cnt_skip;
    } exp_t;

    typedef struct {
        logic [3:0]  cond;
        logic [15:0] mask;
    } cvec_t;

    typedef struct {
        stim_t      s;
        logic [3:0] exp_flags;
        logic       exp_rw;
        logic       exp_mw;
    } dvec_t;

    logic clk;
    logic reset_n;

    int nTests;
    int nFail;

    cond_unit_if #(.CNT_W(32)) bus ();
    cond_unit_if #(.CNT_W(4))  sbus ();

    cond_unit #(.CNT_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    cond_unit #(.CNT_W(4)) dut_small (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sbus)
    );

    cvec_t condTab[16];
    dvec_t dirTab[7];
    exp_t  sbQ[$];

    logic [3:0]  mFlags;
    logic        mValid;
    logic        mRw;
    logic        mMw;
    logic        mPs;
    logic [31:0] mExec;
    logic [31:0] mSkip;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t idleStim();
        stim_t s;
        s.valid = 1'b0; s.stall = 1'b0; s.flush = 1'b0; s.cond = 4'd14;
        s.fw = 2'b00; s.alu = 4'b0000; s.rw = 1'b0; s.mw = 1'b0;
        s.ps = 1'b0; s.nw = 1'b0;
        return s;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        nTests++;
        if (act !== expv) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL scoreboard: got empty queue expected entry");
            return;
        end
        e = sbQ.pop_front();
        checkVal("flags",     32'(bus.flags),     32'(e.flags));
        checkVal("valid_out", 32'(bus.valid_out), 32'(e.valid_out));
        checkVal("reg_write", 32'(bus.reg_write), 32'(e.rw));
        checkVal("mem_write", 32'(bus.mem_write), 32'(e.mw));
        checkVal("pc_src",    32'(bus.pc_src),    32'(e.ps));
        checkVal("cnt_exec",  bus.cnt_exec,       e.cnt_exec);
        checkVal("cnt_skip",  bus.cnt_skip,       e.cnt_skip);
    endtask

    task automatic applyStimulus(input stim_t s);
        logic ok;
        logic ex;
        exp_t e;
        bus.valid_in     = s.valid;
        bus.stall        = s.stall;
        bus.flush        = s.flush;
        bus.cond         = s.cond;
        bus.flag_write   = s.fw;
        bus.alu_flags    = s.alu;
        bus.reg_write_in = s.rw;
        bus.mem_write_in = s.mw;
        bus.pc_src_in    = s.ps;
        bus.no_write_in  = s.nw;
        #1;
        ok = condTab[s.cond].mask[mFlags];
        checkVal($sformatf("cond_ex c=%0d f=%0h", s.cond, mFlags), 32'(bus.cond_ex), 32'(ok));
        ex = s.valid & ok & ~s.flush & ~s.stall;
        if (s.flush) begin
            mValid = 1'b0; mRw = 1'b0; mMw = 1'b0; mPs = 1'b0;
        end else if (!s.stall) begin
            if (ex && s.fw[1]) mFlags[3:2] = s.alu[3:2];
            if (ex && s.fw[0]) mFlags[1:0] = s.alu[1:0];
            mValid = s.valid;
            mRw    = ex & s.rw & ~s.nw;
            mMw    = ex & s.mw;
            mPs    = ex & s.ps;
            if (s.valid && ok)  mExec = mExec + 32'd1;
            if (s.valid && !ok) mSkip = mSkip + 32'd1;
        end
        e.flags = mFlags; e.valid_out = mValid; e.rw = mRw; e.mw = mMw;
        e.ps = mPs; e.cnt_exec = mExec; e.cnt_skip = mSkip;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset applied while a live instruction is presented; everything must clear.
    task automatic doReset();
        stim_t s;
        s = idleStim();
        s.valid = 1'b1; s.rw = 1'b1; s.mw = 1'b1; s.fw = 2'b11; s.alu = 4'b1111;
        bus.valid_in = s.valid; bus.stall = s.stall; bus.flush = s.flush;
        bus.cond = s.cond; bus.flag_write = s.fw; bus.alu_flags = s.alu;
        bus.reg_write_in = s.rw; bus.mem_write_in = s.mw;
        bus.pc_src_in = s.ps; bus.no_write_in = s.nw;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checkVal("rst flags",     32'(bus.flags),     32'h0);
        checkVal("rst valid_out", 32'(bus.valid_out), 32'h0);
        checkVal("rst reg_write", 32'(bus.reg_write), 32'h0);
        checkVal("rst mem_write", 32'(bus.mem_write), 32'h0);
        checkVal("rst pc_src",    32'(bus.pc_src),    32'h0);
        checkVal("rst cnt_exec",  bus.cnt_exec,       32'h0);
        checkVal("rst cnt_skip",  bus.cnt_skip,       32'h0);
        reset_n = 1'b1;
        mFlags = 4'b0000; mValid = 1'b0; mRw = 1'b0; mMw = 1'b0; mPs = 1'b0;
        mExec = 32'd0; mSkip = 32'd0;
        sbQ.delete();
    endtask

    initial begin
        stim_t s;
        nTests = 0;
        nFail  = 0;
        reset_n = 1'b0;

        // Pass masks: bit f set when flags=f satisfies the condition.
        condTab[0]  = '{4'd0,  16'hF0F0};
        condTab[1]  = '{4'd1,  16'h0F0F};
        condTab[2]  = '{4'd2,  16'hCCCC};
        condTab[3]  = '{4'd3,  16'h3333};
        condTab[4]  = '{4'd4,  16'hFF00};
        condTab[5]  = '{4'd5,  16'h00FF};
        condTab[6]  = '{4'd6,  16'hAAAA};
        condTab[7]  = '{4'd7,  16'h5555};
        condTab[8]  = '{4'd8,  16'h0C0C};
        condTab[9]  = '{4'd9,  16'hF3F3};
        condTab[10] = '{4'd10, 16'hAA55};
        condTab[11] = '{4'd11, 16'h55AA};
        condTab[12] = '{4'd12, 16'h0A05};
        condTab[13] = '{4'd13, 16'hF5FA};
        condTab[14] = '{4'd14, 16'hFFFF};
        condTab[15] = '{4'd15, 16'hFFFF};

        // Directed sequence: {valid,stall,flush,cond,fw,alu,rw,mw,ps,nw}, flags, rw, mw
        dirTab[0] = '{'{1'b1,1'b0,1'b0,4'd14,2'b11,4'b0110,1'b0,1'b0,1'b0,1'b0}, 4'b0110, 1'b0, 1'b0};
        dirTab[1] = '{'{1'b1,1'b0,1'b0,4'd0, 2'b00,4'b0000,1'b1,1'b0,1'b0,1'b0}, 4'b0110, 1'b1, 1'b0};
        dirTab[2] = '{'{1'b1,1'b0,1'b0,4'd1, 2'b11,4'b1000,1'b1,1'b1,1'b0,1'b0}, 4'b0110, 1'b0, 1'b0};
        dirTab[3] = '{'{1'b1,1'b0,1'b0,4'd14,2'b11,4'b0000,1'b0,1'b0,1'b0,1'b0}, 4'b0000, 1'b0, 1'b0};
        dirTab[4] = '{'{1'b1,1'b0,1'b0,4'd14,2'b10,4'b1111,1'b0,1'b0,1'b0,1'b0}, 4'b1100, 1'b0, 1'b0};
        dirTab[5] = '{'{1'b1,1'b0,1'b0,4'd14,2'b11,4'b0010,1'b1,1'b0,1'b0,1'b1}, 4'b0010, 1'b0, 1'b0};
        dirTab[6] = '{'{1'b1,1'b0,1'b0,4'd14,2'b00,4'b0000,1'b0,1'b1,1'b1,1'b0}, 4'b0010, 1'b0, 1'b1};

        sbus.valid_in = 1'b0; sbus.stall = 1'b0; sbus.flush = 1'b0;
        sbus.cond = 4'd14; sbus.flag_write = 2'b00; sbus.alu_flags = 4'b0000;
        sbus.reg_write_in = 1'b0; sbus.mem_write_in = 1'b0;
        sbus.pc_src_in = 1'b0; sbus.no_write_in = 1'b0;

        @(posedge clk);
        #1;
        doReset();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(dirTab[i].s);
            checkVal($sformatf("dir%0d flags", i), 32'(bus.flags), 32'(dirTab[i].exp_flags));
            checkVal($sformatf("dir%0d rw", i), 32'(bus.reg_write), 32'(dirTab[i].exp_rw));
            checkVal($sformatf("dir%0d mw", i), 32'(bus.mem_write), 32'(dirTab[i].exp_mw));
        end
        checkVal("dir cnt_exec", bus.cnt_exec, 32'd6);
        checkVal("dir cnt_skip", bus.cnt_skip, 32'd1);
        checkVal("dir pc_src",   32'(bus.pc_src), 32'd1);

        // Stall for three cycles with a flag-writing instruction pending.
        s = idleStim();
        s.valid = 1'b1; s.stall = 1'b1; s.cond = 4'd0; s.fw = 2'b11;
        s.alu = 4'b1111; s.rw = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(s);
        checkVal("stall flags",    32'(bus.flags),     32'b0010);
        checkVal("stall valid",    32'(bus.valid_out), 32'd1);
        checkVal("stall cnt_exec", bus.cnt_exec,       32'd6);
        checkVal("stall cnt_skip", bus.cnt_skip,       32'd1);

        // Flush together with stall gives a bubble and no count.
        s.cond = 4'd14; s.flush = 1'b1;
        applyStimulus(s);
        checkVal("flush valid",    32'(bus.valid_out), 32'd0);
        checkVal("flush rw",       32'(bus.reg_write), 32'd0);
        checkVal("flush flags",    32'(bus.flags),     32'b0010);
        checkVal("flush cnt_exec", bus.cnt_exec,       32'd6);

        // No valid instruction: flag write request must be ignored.
        s = idleStim();
        s.fw = 2'b11; s.alu = 4'b1111; s.rw = 1'b1;
        applyStimulus(s);
        checkVal("idle flags", 32'(bus.flags), 32'b0010);

        // Condition sweep: load each NZCV value, then try every code.
        for (int f = 0; f < 16; f++) begin
            s = idleStim();
            s.valid = 1'b1; s.fw = 2'b11; s.alu = f[3:0];
            applyStimulus(s);
            for (int c = 0; c < 16; c++) begin
                s = idleStim();
                s.cond = c[3:0];
                applyStimulus(s);
            end
        end

        s = idleStim();
        s.valid = 1'b1; s.fw = 2'b11; s.alu = 4'b1001;
        applyStimulus(s);
        bus.valid_in = 1'b0; bus.cond = 4'd10;
        #1;
        checkVal("GE N=1 V=1", 32'(bus.cond_ex), 32'd1);
        s.alu = 4'b1000;
        applyStimulus(s);
        bus.valid_in = 1'b0; bus.cond = 4'd13;
        #1;
        checkVal("LE N=1 Z=0 V=0", 32'(bus.cond_ex), 32'd1);

        // Narrow counter instance: sixteen executions wrap to zero.
        doReset();
        sbus.valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 14) checkVal("wrap cnt 15", 32'(sbus.cnt_exec), 32'd15);
        end
        sbus.valid_in = 1'b0;
        checkVal("wrap cnt 0",    32'(sbus.cnt_exec), 32'd0);
        checkVal("wrap cnt_skip", 32'(sbus.cnt_skip), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Condition/flags stage directly downstream of the ALU.
- Holds the architectural NZCV register and evaluates each instruction's 4-bit ARM condition field against it.
- Latches ALU flags when the instruction executes and requests a flag write.
- Registers the gated write strobes (reg_write, mem_write, pc_src) for the memory/writeback stage, and keeps executed/skipped event counters.

Parameters:
- CNT_W, 32, width of the executed/skipped event counters.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- valid_in  input  1  instruction present at stage input
- stall  input  1  hold stage: no state change
- flush  input  1  kill instruction at stage input
- cond  input  4  ARM condition field, Instr[31:28]
- flag_write  input  2  [1]=update N,Z; [0]=update C,V
- alu_flags  input  4  {N,Z,C,V} from the ALU for this instruction
- reg_write_in  input  1  decoder register-write request
- mem_write_in  input  1  decoder memory-write request
- pc_src_in  input  1  decoder PC-write request (branch or write to R15)
- no_write_in  input  1  compare-class instruction: suppress reg_write
- flags  output  4  current NZCV register {N,Z,C,V}
- cond_ex  output  1  combinational: cond passes against current flags
- valid_out  output  1  registered: stage output holds a live instruction
- reg_write  output  1  registered gated register write
- mem_write  output  1  registered gated memory write
- pc_src  output  1  registered gated PC write
- cnt_exec  output  CNT_W  count of instructions that executed
- cnt_skip  output  CNT_W  count of instructions squashed by their condition

Behaviour:
- Reset (reset_n=0 at a clock edge) clears flags, valid_out, reg_write, mem_write, pc_src, cnt_exec and cnt_skip to 0. Reset mid-operation discards any in-flight instruction.
- Priority at each edge: reset > flush > stall > normal.
- Condition evaluation is combinational from the flags register as it stands before this edge's update.
  - Codes: EQ 0000 Z; NE 0001 ~Z; CS 0010 C; CC 0011 ~C; MI 0100 N; PL 0101 ~N; VS 0110 V; VC 0111 ~V.
  - HI 1000 C&~Z; LS 1001 ~C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 ~Z&(N==V); LE 1101 Z|(N!=V).
  - AL 1110 and 1111 are both 1.
- Define fire = valid_in & cond_ex & ~flush & ~stall.
- Normal cycle (no stall, no flush):
  - flags[3:2] <= alu_flags[3:2] if fire & flag_write[1].
  - flags[1:0] <= alu_flags[1:0] if fire & flag_write[0].
  - valid_out <= valid_in.
  - reg_write <= fire & reg_write_in & ~no_write_in.
  - mem_write <= fire & mem_write_in.
  - pc_src <= fire & pc_src_in.
  - cnt_exec increments when valid_in & cond_ex; cnt_skip increments when valid_in & ~cond_ex.
  - Latency: 1 cycle from input to registered strobes. The flags update is visible to the next instruction's cond_ex one cycle later; there is no same-cycle forwarding.
- Stall: flags, all registered outputs and both counters hold. cond_ex still tracks its inputs.
- Flush: no flag update and no counter change. Next cycle, valid_out and all three strobes are 0 (bubble). Flush overrides a simultaneous stall.
- valid_in=0: the stage outputs a bubble, flags unchanged, counters unchanged.
- Counters wrap modulo 2^CNT_W with no saturation.
- A flag_write by a skipped instruction is ignored entirely.

Decomposition:
- Package cond_pkg holds:
  - cond_e enum (EQ..AL, NV=4'b1111);
  - flag bit index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0;
  - FW_NZ=2'b10, FW_CV=2'b01.
- Sub-module cond_check: purely combinational (cond, flags) -> cond_ex. It is reusable by a later branch-predictor check.
- The stage registers and counters live in cond_unit.

Test Plan:
- Reset, then SUB 5-5 with alu_flags=4'b0110, cond=AL, flag_write=2'b11 -> next cycle flags=0110. A following cond=EQ, reg_write_in=1 gives cond_ex=1 and reg_write=1 one cycle later.
- flags=4'b0110, cond=NE, reg_write_in=1, mem_write_in=1, flag_write=2'b11, alu_flags=4'b1000 -> reg_write=0, mem_write=0, flags remain 0110, cnt_skip +1.
- Sweep all 16 cond codes against all 16 flag values (flags loaded via AL/flag_write=11) -> cond_ex matches the table, including GE with N=1,V=1 (1) and LE with Z=0,N=1,V=0 (1).
- Partial write: flags=4'b0000, flag_write=2'b10, alu_flags=4'b1111, cond=AL -> flags=1100.
- Stall held 3 cycles with valid instruction -> flags, strobes and counters frozen. Stall+flush together -> bubble next cycle and cnt_exec unchanged.
- Compare instruction: no_write_in=1, reg_write_in=1, cond=AL -> reg_write=0, flags updated, cnt_exec +1. cnt_exec preset near wrap via CNT_W=4 build: the 16th increment wraps it to 0.
